// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI transfer arbiter
package spi_arb_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_CFG_W       = 32;
    localparam int DEF_CFG_SETUP   = 2;
    localparam int DEF_TIMEOUT_CYC = 4096;

    // Config word byte lanes as spi_module expects them: {C1, C2, status, baud}
    localparam int CFG_C1_OFS     = 24;
    localparam int CFG_C2_OFS     = 16;
    localparam int CFG_STATUS_OFS = 8;
    localparam int CFG_BAUD_OFS   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    function automatic int cnt_width(input int timeout_cyc, input int setup_cyc);
        int w;
        w = $clog2(timeout_cyc);
        if ($clog2(setup_cyc) > w) w = $clog2(setup_cyc);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_id,
    output logic               o_any
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_any      = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_sum = {1'b0, i_ptr} + SUM_W'(off);
            if (w_sum >= SUM_W'(NUM_REQ)) w_sum = w_sum - SUM_W'(NUM_REQ);
            w_idx = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - shares one spi_module master between NUM_REQ requesters
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int  NUM_REQ     = DEF_NUM_REQ,
    parameter int  DATA_W      = DEF_DATA_W,
    parameter int  CFG_W       = DEF_CFG_W,
    parameter int  CFG_SETUP   = DEF_CFG_SETUP,
    parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ*CFG_W-1:0]  i_req_cfg,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_rsp_err,
    output logic [DATA_W-1:0]         o_spi_data,
    output logic [CFG_W-1:0]          o_spi_config,
    output logic                      o_spi_trans_en,
    input  logic                      i_spi_interrupt,
    input  logic [DATA_W-1:0]         i_spi_data,
    output logic                      o_busy,
    output logic [IDX_W-1:0]          o_grant_id
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC, CFG_SETUP);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_grant_id;
    logic [DATA_W-1:0] r_spi_data;
    logic [CFG_W-1:0]  r_spi_cfg;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_id;
    logic               w_any;
    logic [DATA_W-1:0]  w_sel_data;
    logic [CFG_W-1:0]   w_sel_cfg;
    logic               w_timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req      (i_req_valid),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        w_sel_cfg  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_id == IDX_W'(k)) begin
                w_sel_data = i_req_data[k*DATA_W +: DATA_W];
                w_sel_cfg  = i_req_cfg[k*CFG_W +: CFG_W];
            end
        end
    end

    // The trans_en cycle is cycle 0 of the window, so the response lands TIMEOUT_CYC cycles after it.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 2));

    always_comb begin
        w_next_state   = r_state;
        o_req_ready    = '0;
        o_spi_trans_en = 1'b0;
        o_rsp_valid    = '0;
        o_busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (!i_sys_rst) o_req_ready = w_grant;
                if (w_any) w_next_state = ST_SETUP;
            end
            ST_SETUP: begin
                if (r_cnt == CNT_W'(CFG_SETUP - 1)) w_next_state = ST_START;
            end
            ST_START: begin
                o_spi_trans_en = 1'b1;
                w_next_state   = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_spi_interrupt || w_timeout) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid[r_grant_id] = 1'b1;
                w_next_state            = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_spi_data <= '0;
            r_spi_cfg  <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_spi_data <= w_sel_data;
                        r_spi_cfg  <= w_sel_cfg;
                        r_grant_id <= w_grant_id;
                        r_ptr      <= (w_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_id + IDX_W'(1);
                        r_cnt      <= '0;
                    end
                end
                ST_SETUP: r_cnt <= r_cnt + CNT_W'(1);
                ST_START: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Completion wins over a simultaneous timeout.
                    if (i_spi_interrupt) begin
                        r_rsp_data <= i_spi_data;
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_spi_data   = r_spi_data;
    assign o_spi_config = r_spi_cfg;
    assign o_grant_id   = r_grant_id;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - self-checking bench for spi_xfer_arbiter
module tb_spi_xfer_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int CW   = 32;
    localparam int SETUP = 2;
    localparam int TMO  = 64;

    logic            clk = 1'b0;
    logic            i_sys_rst;
    logic [NREQ-1:0] i_req_valid;
    logic [NREQ-1:0] o_req_ready;
    logic [NREQ*DW-1:0] i_req_data;
    logic [NREQ*CW-1:0] i_req_cfg;
    logic [NREQ-1:0] o_rsp_valid;
    logic [DW-1:0]   o_rsp_data;
    logic            o_rsp_err;
    logic [DW-1:0]   o_spi_data;
    logic [CW-1:0]   o_spi_config;
    logic            o_spi_trans_en;
    logic            i_spi_interrupt;
    logic [DW-1:0]   i_spi_data;
    logic            o_busy;
    logic [1:0]      o_grant_id;

    int cyc, since_en, spi_delay, model_ptr;
    logic [7:0] spi_rx;
    bit spur;
    int n_checks, n_fail;

    always #5 clk = ~clk;

    spi_xfer_arbiter #(
        .NUM_REQ(NREQ), .DATA_W(DW), .CFG_W(CW), .CFG_SETUP(SETUP), .TIMEOUT_CYC(TMO)
    ) dut (
        .i_sys_clk(clk), .i_sys_rst(i_sys_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_data(i_req_data), .i_req_cfg(i_req_cfg),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_spi_data(o_spi_data), .o_spi_config(o_spi_config), .o_spi_trans_en(o_spi_trans_en),
        .i_spi_interrupt(i_spi_interrupt), .i_spi_data(i_spi_data),
        .o_busy(o_busy), .o_grant_id(o_grant_id)
    );

    // One clock; also plays the SPI slave: interrupt spi_delay cycles after trans_en (0 = never).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_rsp_valid != '0) since_en = -1;
        else if (since_en >= 0) since_en++;
        if (o_spi_trans_en) since_en = 0;
        i_spi_interrupt = (spur && since_en <= 0) || (spi_delay > 0 && since_en == spi_delay);
        i_spi_data = i_spi_interrupt ? spi_rx : 8'($urandom);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] d, input logic [31:0] c);
        i_req_data[k*DW +: DW] = d;
        i_req_cfg[k*CW +: CW]  = c;
    endtask

    task automatic do_reset();
        i_sys_rst = 1'b1;
        i_req_valid = '0;
        tick();
        tick();
        i_sys_rst = 1'b0;
        since_en = -1;
        model_ptr = 0;
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        for (int o = 0; o < NREQ; o++)
            if (v[(ptr + o) % NREQ]) return (ptr + o) % NREQ;
        return -1;
    endfunction

    // Drives one request and records what the DUT did; the callers judge it.
    task automatic run_one(input int k, input logic [7:0] d, input logic [31:0] c,
                           output logic [3:0] rdy, output int g_cyc,
                           output logic [7:0] sdata, output logic [31:0] scfg, output logic [1:0] gid,
                           output int en_cyc, output int en_cnt, output int rsp_cyc,
                           output logic [3:0] rv, output logic [7:0] rd, output logic rerr);
        tick();
        set_req(k, d, c);
        i_req_valid = 4'(1 << k);
        #1;
        rdy = o_req_ready;
        g_cyc = cyc;
        tick();
        i_req_valid = '0;
        #1;
        sdata = o_spi_data;
        scfg = o_spi_config;
        gid = o_grant_id;
        en_cyc = -1; en_cnt = 0; rsp_cyc = -1; rv = '0; rd = '0; rerr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_spi_trans_en) begin
                en_cnt++;
                if (en_cyc < 0) en_cyc = cyc;
            end
            if (o_rsp_valid != '0) begin
                rsp_cyc = cyc; rv = o_rsp_valid; rd = o_rsp_data; rerr = o_rsp_err;
                break;
            end
            tick();
            #1;
        end
        model_ptr = (k + 1) % NREQ;
    endtask

    task automatic test_reset();
        i_sys_rst = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if ({o_req_ready, o_rsp_valid, o_spi_trans_en, o_busy, o_rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b rsp=%b en=%b busy=%b err=%b required all 0",
                     o_req_ready, o_rsp_valid, o_spi_trans_en, o_busy, o_rsp_err);
        end
        n_checks++;
        if ({o_spi_data, o_spi_config, o_rsp_data, o_grant_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: spi_data=%h cfg=%h rsp_data=%h gid=%0d required 0",
                     o_spi_data, o_spi_config, o_rsp_data, o_grant_id);
        end
        i_sys_rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_single();
        logic [3:0] rdy, rv; int g_cyc, en_cyc, en_cnt, rsp_cyc;
        logic [7:0] sdata, rd; logic [31:0] scfg; logic [1:0] gid; logic rerr;
        spi_delay = 20; spi_rx = 8'h3C;
        run_one(1, 8'hA5, 32'hD6108011, rdy, g_cyc, sdata, scfg, gid, en_cyc, en_cnt, rsp_cyc, rv, rd, rerr);
        n_checks++;
        if (rdy !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b required 0010", rdy); end
        n_checks++;
        if (scfg !== 32'hD6108011 || sdata !== 8'hA5 || gid !== 2'd1) begin
            n_fail++; $display("FAIL single_spi_out: cfg=%h data=%h gid=%0d required D6108011 A5 1", scfg, sdata, gid);
        end
        n_checks++;
        if (en_cnt !== 1 || en_cyc !== g_cyc + SETUP + 1) begin
            n_fail++; $display("FAIL single_trans_en: pulses=%0d at +%0d required 1 at +3", en_cnt, en_cyc - g_cyc);
        end
        n_checks++;
        if (rsp_cyc !== en_cyc + 21 || rv !== 4'b0010 || rd !== 8'h3C || rerr !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: cyc+%0d valid=%b data=%h err=%b required +21 0010 3c 0",
                               rsp_cyc - en_cyc, rv, rd, rerr);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] pend; logic [7:0] ed[NREQ]; logic [31:0] ec[NREQ];
        int cur, grants, rsps, last_rsp, g_cyc, g;
        int exp_order[5];
        do_reset();
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < NREQ; k++) begin
            ed[k] = 8'($urandom); ec[k] = $urandom; set_req(k, ed[k], ec[k]);
        end
        pend = 4'hF; grants = 0; rsps = 0; cur = 0; last_rsp = -1; g_cyc = -10;
        for (int i = 0; i < 800 && rsps < 5; i++) begin
            tick();
            i_req_valid = pend;
            #1;
            if (o_req_ready != '0) begin
                g = rr_pick(pend, model_ptr);
                n_checks++;
                if (o_req_ready !== 4'(1 << g) || o_req_ready !== 4'(1 << exp_order[grants])) begin
                    n_fail++; $display("FAIL rr_grant: #%0d ready=%b required %0d", grants, o_req_ready, g);
                end
                n_checks++;
                if (o_busy !== 1'b0 || (grants > 0 && cyc !== last_rsp + 1)) begin
                    n_fail++; $display("FAIL rr_idle_gap: busy=%b gap=%0d required 0 and 1", o_busy, cyc - last_rsp);
                end
                cur = g; pend[g] = 1'b0; model_ptr = (g + 1) % NREQ; grants++; g_cyc = cyc;
                spi_delay = $urandom_range(1, 30); spi_rx = 8'($urandom);
            end else begin
                if (cyc == g_cyc + 1) begin
                    n_checks++;
                    if (o_spi_data !== ed[cur] || o_spi_config !== ec[cur] || o_grant_id !== 2'(cur)) begin
                        n_fail++; $display("FAIL rr_spi_out: data=%h cfg=%h gid=%0d required %h %h %0d",
                                           o_spi_data, o_spi_config, o_grant_id, ed[cur], ec[cur], cur);
                    end
                end
                if (grants > rsps) begin
                    n_checks++;
                    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy: got %b required 1", o_busy); end
                end
            end
            if (o_rsp_valid != '0) begin
                n_checks++;
                if (o_rsp_valid !== 4'(1 << cur) || o_rsp_data !== spi_rx || o_rsp_err !== 1'b0) begin
                    n_fail++; $display("FAIL rr_rsp: valid=%b data=%h err=%b required %b %h 0",
                                       o_rsp_valid, o_rsp_data, o_rsp_err, 4'(1 << cur), spi_rx);
                end
                rsps++; last_rsp = cyc;
                if (rsps < 5) begin
                    ed[cur] = 8'($urandom); ec[cur] = $urandom; set_req(cur, ed[cur], ec[cur]); pend[cur] = 1'b1;
                end
            end
        end
        i_req_valid = '0;
        n_checks++;
        if (rsps !== 5) begin n_fail++; $display("FAIL rr_count: responses=%0d required 5", rsps); end
    endtask

    task automatic test_timeout();
        logic [3:0] rdy, rv; int g_cyc, en_cyc, en_cnt, rsp_cyc, k;
        logic [7:0] sdata, rd, d; logic [31:0] scfg; logic [1:0] gid; logic rerr;
        k = $urandom_range(0, NREQ - 1);
        spi_delay = 0;
        run_one(k, 8'($urandom), $urandom, rdy, g_cyc, sdata, scfg, gid, en_cyc, en_cnt, rsp_cyc, rv, rd, rerr);
        n_checks++;
        if (rsp_cyc !== en_cyc + TMO || rv !== 4'(1 << k) || rd !== 8'h00 || rerr !== 1'b1) begin
            n_fail++; $display("FAIL timeout_rsp: cyc+%0d valid=%b data=%h err=%b required +%0d %b 00 1",
                               rsp_cyc - en_cyc, rv, rd, rerr, TMO, 4'(1 << k));
        end
        k = $urandom_range(0, NREQ - 1);
        d = 8'($urandom);
        spi_delay = $urandom_range(1, 40); spi_rx = 8'($urandom);
        run_one(k, d, $urandom, rdy, g_cyc, sdata, scfg, gid, en_cyc, en_cnt, rsp_cyc, rv, rd, rerr);
        n_checks++;
        if (rdy !== 4'(1 << k) || sdata !== d || rsp_cyc !== en_cyc + spi_delay + 1 ||
            rd !== spi_rx || rerr !== 1'b0) begin
            n_fail++; $display("FAIL after_timeout: ready=%b data=%h rsp=%h err=%b required %b %h %h 0",
                               rdy, sdata, rd, rerr, 4'(1 << k), d, spi_rx);
        end
    endtask

    task automatic test_int_on_timeout();
        logic [3:0] rdy, rv; int g_cyc, en_cyc, en_cnt, rsp_cyc;
        logic [7:0] sdata, rd; logic [31:0] scfg; logic [1:0] gid; logic rerr;
        spi_delay = TMO - 1; spi_rx = 8'($urandom);
        run_one(2, 8'($urandom), $urandom, rdy, g_cyc, sdata, scfg, gid, en_cyc, en_cnt, rsp_cyc, rv, rd, rerr);
        n_checks++;
        if (rsp_cyc !== en_cyc + TMO || rd !== spi_rx || rerr !== 1'b0) begin
            n_fail++; $display("FAIL int_at_timeout: cyc+%0d data=%h err=%b required +%0d %h 0",
                               rsp_cyc - en_cyc, rd, rerr, TMO, spi_rx);
        end
    endtask

    task automatic test_spurious();
        logic [3:0] rdy, rv; int g_cyc, en_cyc, en_cnt, rsp_cyc;
        logic [7:0] sdata, rd; logic [31:0] scfg; logic [1:0] gid; logic rerr;
        spur = 1'b1; spi_delay = 10; spi_rx = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            n_checks++;
            if (o_busy !== 1'b0 || o_rsp_valid !== '0) begin
                n_fail++; $display("FAIL spurious_idle: busy=%b rsp=%b required 0 0000", o_busy, o_rsp_valid);
            end
        end
        run_one(3, 8'($urandom), $urandom, rdy, g_cyc, sdata, scfg, gid, en_cyc, en_cnt, rsp_cyc, rv, rd, rerr);
        spur = 1'b0;
        n_checks++;
        if (en_cyc !== g_cyc + SETUP + 1 || rsp_cyc !== en_cyc + 11 || rd !== spi_rx || rerr !== 1'b0) begin
            n_fail++; $display("FAIL spurious_setup: en+%0d rsp+%0d data=%h err=%b required +3 +11 %h 0",
                               en_cyc - g_cyc, rsp_cyc - en_cyc, rd, rerr, spi_rx);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d2; logic [31:0] c2; bit got;
        spi_delay = 0;
        tick();
        set_req(0, 8'($urandom), $urandom);
        i_req_valid = 4'b0001;
        #1;
        tick();
        i_req_valid = '0;
        for (int i = 0; i < 8; i++) tick();
        #1;
        n_checks++;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b required 1", o_busy); end
        d2 = 8'($urandom); c2 = $urandom;
        set_req(2, d2, c2);
        i_req_valid = 4'b0100;
        i_sys_rst = 1'b1;
        tick();
        #1;
        n_checks++;
        if ({o_req_ready, o_rsp_valid, o_spi_trans_en, o_busy, o_rsp_err, o_spi_data, o_spi_config,
             o_rsp_data, o_grant_id} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: ready=%b rsp=%b busy=%b data=%h cfg=%h gid=%0d required all 0",
                               o_req_ready, o_rsp_valid, o_busy, o_spi_data, o_spi_config, o_grant_id);
        end
        i_sys_rst = 1'b0; since_en = -1;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_regrant: ready=%b required 0100", o_req_ready); end
        spi_delay = 5; spi_rx = 8'($urandom);
        tick();
        i_req_valid = '0;
        #1;
        n_checks++;
        if (o_grant_id !== 2'd2 || o_spi_data !== d2 || o_spi_config !== c2) begin
            n_fail++; $display("FAIL mid_spi_out: gid=%0d data=%h cfg=%h required 2 %h %h", o_grant_id, o_spi_data, o_spi_config, d2, c2);
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            #1;
            if (o_rsp_valid != '0) begin
                got = 1;
                n_checks++;
                if (o_rsp_valid !== 4'b0100 || o_rsp_data !== spi_rx || o_rsp_err !== 1'b0) begin
                    n_fail++; $display("FAIL mid_rsp: valid=%b data=%h err=%b required 0100 %h 0", o_rsp_valid, o_rsp_data, o_rsp_err, spi_rx);
                end
            end
        end
        if (!got) begin n_checks++; n_fail++; $display("FAIL mid_rsp_missing: no response within 40 cycles"); end
        // Pointer now sits at 3; a reset must bring it back to 0 so requester 1 wins over 2 and 3.
        i_req_valid = 4'b1110;
        i_sys_rst = 1'b1;
        tick();
        i_sys_rst = 1'b0; since_en = -1;
        #1;
        n_checks++;
        if (o_req_ready !== 4'b0010) begin n_fail++; $display("FAIL ptr_after_reset: ready=%b required 0010", o_req_ready); end
        tick();
        i_req_valid = '0;
        for (int i = 0; i < 20; i++) tick();
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; since_en = -1; spi_delay = 0; spur = 1'b0; spi_rx = '0;
        i_sys_rst = 1'b1; i_req_valid = '0; i_req_data = '0; i_req_cfg = '0;
        i_spi_interrupt = 1'b0; i_spi_data = '0; model_ptr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_int_on_timeout();
        test_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
